// File: rtl/shift_feeder_if.sv
// Word handshake plus shift-register control bundle between a word source and the feeder.
interface shift_feeder_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             hold;
  logic             load;
  logic             ena;
  logic [WIDTH-1:0] data;
  logic             busy;
  logic             done;
  logic [7:0]       word_cnt;

  modport master (
    output in_valid, in_data, hold,
    input  in_ready, load, ena, data, busy, done, word_cnt
  );

  modport slave (
    input  in_valid, in_data, hold,
    output in_ready, load, ena, data, busy, done, word_cnt
  );
endinterface

// File: rtl/shift_feeder.sv
// Sequencer feeding a zero-fill shift-right register: one load pulse, then SHIFTS
// ena pulses per accepted word, with hold-based throttling and a wrapping word count.
module shift_feeder #(
  parameter int WIDTH  = 4,
  parameter int SHIFTS = 4
) (
  input  logic         clk,
  input  logic         areset_n,
  shift_feeder_if.slave bus
);
  localparam logic [7:0] SHIFTS_C = 8'(SHIFTS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [7:0]       cnt_q;
  logic [7:0]       cnt_d;
  logic [WIDTH-1:0] data_q;
  logic [7:0]       word_cnt_q;
  logic [7:0]       word_cnt_d;
  logic             in_ready;
  logic             accept;

  assign cnt_d      = cnt_q - 8'd1;
  assign word_cnt_d = word_cnt_q + 8'd1;

  // Strobes decode the registered state; reset gates them off immediately.
  assign in_ready     = areset_n && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign accept       = bus.in_valid && in_ready;
  assign bus.in_ready = in_ready;
  assign bus.load     = areset_n && (state_q == S_LOAD);
  assign bus.ena      = areset_n && (state_q == S_SHIFT) && !bus.hold;
  assign bus.busy     = areset_n && ((state_q == S_LOAD) || (state_q == S_SHIFT));
  assign bus.done     = areset_n && (state_q == S_DONE);
  assign bus.data     = data_q;
  assign bus.word_cnt = word_cnt_q;

  always_ff @(posedge clk) begin
    if (!areset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      data_q     <= '0;
      word_cnt_q <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            data_q  <= bus.in_data;
            cnt_q   <= SHIFTS_C;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          // Counter and state freeze while the consumer holds off shifting.
          if (!bus.hold) begin
            cnt_q <= cnt_d;
            if (cnt_q == 8'd1) begin
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          word_cnt_q <= word_cnt_d;
          if (accept) begin
            data_q  <= bus.in_data;
            cnt_q   <= SHIFTS_C;
            state_q <= S_LOAD;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_shift_feeder.sv
// Directed bench: a SHIFTS=4 feeder driving a reference shift register, plus a SHIFTS=1 feeder.
module tb_shift_feeder;
  // Control vector order: {load, ena, done, busy, in_ready}
  localparam logic [4:0] C_L = 5'b10010;
  localparam logic [4:0] C_E = 5'b01010;
  localparam logic [4:0] C_H = 5'b00010;
  localparam logic [4:0] C_D = 5'b00101;
  localparam logic [4:0] C_I = 5'b00001;
  localparam logic [4:0] C_R = 5'b00000;

  localparam logic [4:0] SW_CTRL [1:7] = '{C_L, C_E, C_E, C_E, C_E, C_D, C_I};
  localparam logic [3:0] SW_Q    [1:7] = '{4'b0000, 4'b1011, 4'b0101, 4'b0010, 4'b0001, 4'b0000, 4'b0000};

  localparam logic [4:0] ST_CTRL [1:10] = '{C_L, C_E, C_H, C_H, C_H, C_E, C_E, C_E, C_D, C_I};
  localparam logic       ST_HOLD [1:10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [3:0] ST_Q    [1:10] = '{4'b0000, 4'b1011, 4'b0101, 4'b0101, 4'b0101,
                                            4'b0101, 4'b0010, 4'b0001, 4'b0000, 4'b0000};

  localparam logic [4:0] BB_CTRL [1:13] = '{C_L, C_E, C_E, C_E, C_E, C_D, C_L, C_E, C_E, C_E, C_E, C_D, C_I};
  localparam logic       BB_V    [1:13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                                            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [3:0] BB_DATA [1:13] = '{4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'h5,
                                            4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5};
  localparam logic [3:0] BB_Q    [1:13] = '{4'b0000, 4'b1010, 4'b0101, 4'b0010, 4'b0001, 4'b0000, 4'b0000,
                                            4'b0101, 4'b0010, 4'b0001, 4'b0000, 4'b0000, 4'b0000};

  logic clk;
  logic areset_n;
  logic [3:0] q0;
  int n_checks;
  int n_pass;

  shift_feeder_if #(.WIDTH(4)) bus0 ();
  shift_feeder_if #(.WIDTH(4)) bus1 ();

  shift_feeder #(.WIDTH(4), .SHIFTS(4)) u_dut4 (
    .clk      (clk),
    .areset_n (areset_n),
    .bus      (bus0)
  );

  shift_feeder #(.WIDTH(4), .SHIFTS(1)) u_dut1 (
    .clk      (clk),
    .areset_n (areset_n),
    .bus      (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference 4-bit shift-right register: zero fill, load wins over ena.
  always_ff @(posedge clk) begin
    if (!areset_n) q0 <= 4'b0000;
    else if (bus0.load) q0 <= bus0.data;
    else if (bus0.ena) q0 <= q0 >> 1;
  end

  function automatic logic [4:0] ctrl0();
    return {bus0.load, bus0.ena, bus0.done, bus0.busy, bus0.in_ready};
  endfunction

  function automatic logic [4:0] ctrl1();
    return {bus1.load, bus1.ena, bus1.done, bus1.busy, bus1.in_ready};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input logic v, input logic [3:0] d, input logic h, input logic rst_n);
    @(posedge clk);
    #1;
    bus0.in_valid = v;
    bus0.in_data  = d;
    bus0.hold     = h;
    areset_n      = rst_n;
    #1;
  endtask

  task automatic step1(input logic v, input logic [3:0] d, input logic h);
    @(posedge clk);
    #1;
    bus1.in_valid = v;
    bus1.in_data  = d;
    bus1.hold     = h;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int gap_bad;
    logic seen_done;
    n_checks      = 0;
    n_pass        = 0;
    areset_n      = 1'b0;
    bus0.in_valid = 1'b1;
    bus0.in_data  = 4'hF;
    bus0.hold     = 1'b0;
    bus1.in_valid = 1'b0;
    bus1.in_data  = 4'h0;
    bus1.hold     = 1'b0;

    // Reset with in_valid high
    for (int j = 0; j < 2; j++) begin
      step(1'b1, 4'hF, 1'b0, 1'b0);
      check($sformatf("rst_ctrl[%0d]", j), 32'(ctrl0()), 32'(C_R));
      check($sformatf("rst_data[%0d]", j), 32'(bus0.data), 32'h0);
      check($sformatf("rst_wcnt[%0d]", j), 32'(bus0.word_cnt), 32'h0);
    end
    step(1'b0, 4'h0, 1'b0, 1'b1);
    check("rel_ctrl", 32'(ctrl0()), 32'(C_I));

    // Single word 1011
    step(1'b1, 4'b1011, 1'b0, 1'b1);
    check("sw_acc_ctrl", 32'(ctrl0()), 32'(C_I));
    for (int j = 1; j <= 7; j++) begin
      step(1'b0, 4'h0, 1'b0, 1'b1);
      check($sformatf("sw_ctrl[%0d]", j), 32'(ctrl0()), 32'(SW_CTRL[j]));
      check($sformatf("sw_q[%0d]", j), 32'(q0), 32'(SW_Q[j]));
      if (j == 1) check("sw_data", 32'(bus0.data), 32'hB);
      if (j == 6) check("sw_wcnt_done", 32'(bus0.word_cnt), 32'd0);
      if (j == 7) check("sw_wcnt", 32'(bus0.word_cnt), 32'd1);
    end

    // Stall for three cycles mid-word
    step(1'b1, 4'b1011, 1'b0, 1'b1);
    for (int j = 1; j <= 10; j++) begin
      step(1'b0, 4'h0, ST_HOLD[j], 1'b1);
      check($sformatf("st_ctrl[%0d]", j), 32'(ctrl0()), 32'(ST_CTRL[j]));
      check($sformatf("st_q[%0d]", j), 32'(q0), 32'(ST_Q[j]));
      if (j == 10) check("st_wcnt", 32'(bus0.word_cnt), 32'd2);
    end

    // Back-to-back words A then 5 with in_valid held high
    step(1'b1, 4'hA, 1'b0, 1'b1);
    for (int j = 1; j <= 13; j++) begin
      step(BB_V[j], 4'h5, 1'b0, 1'b1);
      check($sformatf("bb_ctrl[%0d]", j), 32'(ctrl0()), 32'(BB_CTRL[j]));
      check($sformatf("bb_data[%0d]", j), 32'(bus0.data), 32'(BB_DATA[j]));
      check($sformatf("bb_q[%0d]", j), 32'(q0), 32'(BB_Q[j]));
      if (j == 7) check("bb_wcnt_mid", 32'(bus0.word_cnt), 32'd3);
      if (j == 13) check("bb_wcnt", 32'(bus0.word_cnt), 32'd4);
    end

    // Reset in the middle of shifting
    step(1'b1, 4'b1011, 1'b0, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    check("mr_load", 32'(ctrl0()), 32'(C_L));
    step(1'b0, 4'h0, 1'b0, 1'b1);
    check("mr_shift", 32'(ctrl0()), 32'(C_E));
    step(1'b0, 4'h0, 1'b0, 1'b0);
    check("mr_rst_ctrl", 32'(ctrl0()), 32'(C_R));
    for (int j = 4; j <= 9; j++) begin
      step(1'b0, 4'h0, 1'b0, 1'b1);
      check($sformatf("mr_idle[%0d]", j), 32'(ctrl0()), 32'(C_I));
      if (j == 4) begin
        check("mr_data", 32'(bus0.data), 32'h0);
        check("mr_wcnt", 32'(bus0.word_cnt), 32'd0);
      end
    end
    step(1'b1, 4'h6, 1'b0, 1'b1);
    for (int j = 1; j <= 7; j++) begin
      step(1'b0, 4'h0, 1'b0, 1'b1);
      check($sformatf("mr_re_ctrl[%0d]", j), 32'(ctrl0()), 32'(SW_CTRL[j]));
      if (j == 1) check("mr_re_data", 32'(bus0.data), 32'h6);
      if (j == 7) check("mr_re_wcnt", 32'(bus0.word_cnt), 32'd1);
    end

    // 256 consecutive words: word_cnt wraps
    step(1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b1, 4'h0, 1'b0, 1'b1);
    gap_bad = 0;
    for (int k = 1; k <= 256; k++) begin
      n = 0;
      seen_done = 1'b0;
      while (!seen_done && n < 12) begin
        step(1'b1, 4'(k), 1'b0, 1'b1);
        n = n + 1;
        seen_done = bus0.done;
      end
      if (n != 6) gap_bad = gap_bad + 1;
      if (k == 256) check("wrap_wcnt_255", 32'(bus0.word_cnt), 32'd255);
    end
    check("wrap_gap", 32'(gap_bad), 32'd0);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    check("wrap_wcnt_0", 32'(bus0.word_cnt), 32'd0);
    check("wrap_next_load", 32'(ctrl0()), 32'(C_L));
    n = 0;
    seen_done = 1'b0;
    while (!seen_done && n < 12) begin
      step(1'b0, 4'h0, 1'b0, 1'b1);
      n = n + 1;
      seen_done = bus0.done;
    end
    check("wrap_drain_cycles", 32'(n), 32'd5);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    check("wrap_wcnt_1", 32'(bus0.word_cnt), 32'd1);

    // SHIFTS=1 feeder: single ena per word, then a held cycle
    step1(1'b1, 4'h9, 1'b0);
    check("s1_acc", 32'(ctrl1()), 32'(C_I));
    step1(1'b0, 4'h0, 1'b0);
    check("s1_load", 32'(ctrl1()), 32'(C_L));
    check("s1_data", 32'(bus1.data), 32'h9);
    step1(1'b0, 4'h0, 1'b0);
    check("s1_ena", 32'(ctrl1()), 32'(C_E));
    step1(1'b0, 4'h0, 1'b0);
    check("s1_done", 32'(ctrl1()), 32'(C_D));
    step1(1'b0, 4'h0, 1'b0);
    check("s1_idle", 32'(ctrl1()), 32'(C_I));
    check("s1_wcnt", 32'(bus1.word_cnt), 32'd1);
    step1(1'b1, 4'h3, 1'b0);
    step1(1'b0, 4'h0, 1'b0);
    check("s1h_load", 32'(ctrl1()), 32'(C_L));
    step1(1'b0, 4'h0, 1'b1);
    check("s1h_held", 32'(ctrl1()), 32'(C_H));
    step1(1'b0, 4'h0, 1'b0);
    check("s1h_ena", 32'(ctrl1()), 32'(C_E));
    step1(1'b0, 4'h0, 1'b0);
    check("s1h_done", 32'(ctrl1()), 32'(C_D));
    step1(1'b0, 4'h0, 1'b0);
    check("s1h_wcnt", 32'(bus1.word_cnt), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
